// File: rtl/aes_gctr_sched.sv
// GCM encryption job sequencer: time-shares one combinational AES core to produce
// H = E(K,0), EJ0 = E(K,J0) and a valid/ready keystream E(K,CB_i) for N counter blocks.
module aes_gctr_sched #(
    parameter int AES_LAT = 1,
    parameter int NB_W    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [127:0]    key,
    input  logic [127:0]    j0,
    input  logic [NB_W-1:0] num_blocks,
    output logic [127:0]    aes_pt,
    output logic [127:0]    aes_key,
    input  logic [127:0]    aes_ct,
    output logic            busy,
    output logic [127:0]    h_out,
    output logic            h_valid,
    output logic [127:0]    ej0_out,
    output logic            ej0_valid,
    output logic [127:0]    ks_data,
    output logic            ks_valid,
    input  logic            ks_ready,
    output logic            ks_last,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        H_GEN   = 3'd1,
        J0_GEN  = 3'd2,
        KS_GEN  = 3'd3,
        KS_HOLD = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam int               WC_W    = (AES_LAT > 1) ? $clog2(AES_LAT) : 1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(AES_LAT - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [127:0]      key_reg;
    logic [127:0]      j0_reg;
    logic [127:0]      ctr_reg;
    logic [NB_W-1:0]   rem_reg;
    logic [WC_W-1:0]   wcnt_reg;
    logic [127:0]      h_out_reg;
    logic              h_valid_reg;
    logic [127:0]      ej0_out_reg;
    logic              ej0_valid_reg;
    logic [127:0]      ks_data_reg;
    logic              ks_valid_reg;
    logic              ks_last_reg;
    logic              done_reg;

    logic              gen_state;
    logic              last_wait;
    logic              rem_is_one;
    logic              ks_fire;

    // Only the low 32 bits count; the upper 96 bits of the counter block are fixed.
    function automatic logic [127:0] inc32(input logic [127:0] v);
        return {v[127:32], v[31:0] + 32'd1};
    endfunction

    assign gen_state  = (state_reg == H_GEN) || (state_reg == J0_GEN) || (state_reg == KS_GEN);
    assign last_wait  = gen_state && (wcnt_reg == WC_LAST);
    assign rem_is_one = (rem_reg == NB_W'(1));
    assign ks_fire    = (state_reg == KS_HOLD) && ks_valid_reg && ks_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = H_GEN;
                end
            end
            H_GEN: begin
                if (last_wait) begin
                    state_next = J0_GEN;
                end
            end
            J0_GEN: begin
                if (last_wait) begin
                    state_next = (rem_reg != '0) ? KS_GEN : FIN;
                end
            end
            KS_GEN: begin
                if (last_wait) begin
                    state_next = KS_HOLD;
                end
            end
            KS_HOLD: begin
                if (ks_fire) begin
                    state_next = rem_is_one ? FIN : KS_GEN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        aes_pt = 128'h0;
        case (state_reg)
            J0_GEN:  aes_pt = j0_reg;
            KS_GEN:  aes_pt = ctr_reg;
            default: aes_pt = 128'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg       <= '0;
            j0_reg        <= '0;
            ctr_reg       <= '0;
            rem_reg       <= '0;
            wcnt_reg      <= '0;
            h_out_reg     <= '0;
            h_valid_reg   <= 1'b0;
            ej0_out_reg   <= '0;
            ej0_valid_reg <= 1'b0;
            ks_data_reg   <= '0;
            ks_valid_reg  <= 1'b0;
            ks_last_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else if (abort) begin
            wcnt_reg      <= '0;
            h_valid_reg   <= 1'b0;
            ej0_valid_reg <= 1'b0;
            ks_valid_reg  <= 1'b0;
            ks_last_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= (state_next == FIN);

            // Settle counter runs only inside the GEN states and restarts for each job.
            if (gen_state && !last_wait) begin
                wcnt_reg <= wcnt_reg + WC_W'(1);
            end else begin
                wcnt_reg <= '0;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        key_reg       <= key;
                        j0_reg        <= j0;
                        ctr_reg       <= inc32(j0);
                        rem_reg       <= num_blocks;
                        h_valid_reg   <= 1'b0;
                        ej0_valid_reg <= 1'b0;
                    end
                end
                H_GEN: begin
                    if (last_wait) begin
                        h_out_reg   <= aes_ct;
                        h_valid_reg <= 1'b1;
                    end
                end
                J0_GEN: begin
                    if (last_wait) begin
                        ej0_out_reg   <= aes_ct;
                        ej0_valid_reg <= 1'b1;
                    end
                end
                KS_GEN: begin
                    if (last_wait) begin
                        ks_data_reg  <= aes_ct;
                        ks_valid_reg <= 1'b1;
                        ks_last_reg  <= rem_is_one;
                    end
                end
                KS_HOLD: begin
                    if (ks_fire) begin
                        ks_valid_reg <= 1'b0;
                        ks_last_reg  <= 1'b0;
                        ctr_reg      <= inc32(ctr_reg);
                        rem_reg      <= rem_reg - NB_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign aes_key   = key_reg;
    assign busy      = (state_reg != IDLE);
    assign h_out     = h_out_reg;
    assign h_valid   = h_valid_reg;
    assign ej0_out   = ej0_out_reg;
    assign ej0_valid = ej0_valid_reg;
    assign ks_data   = ks_data_reg;
    assign ks_valid  = ks_valid_reg;
    assign ks_last   = ks_last_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_aes_gctr_sched.sv
// Directed bench for aes_gctr_sched: a stand-in AES model drives aes_ct, a keystream
// scoreboard is filled at start and drained on each handshake; a second instance uses AES_LAT=3.
module tb_aes_gctr_sched;

    localparam int NB_W = 16;
    localparam int LAT3 = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            abort;
    logic [127:0]    key;
    logic [127:0]    j0;
    logic [NB_W-1:0] num_blocks;

    logic            start1, ks_ready1;
    logic [127:0]    aes_pt1, aes_key1, aes_ct1, h_out1, ej0_out1, ks_data1;
    logic            busy1, h_valid1, ej0_valid1, ks_valid1, ks_last1, done1;

    logic            start3, ks_ready3;
    logic [127:0]    aes_pt3, aes_key3, aes_ct3, h_out3, ej0_out3, ks_data3;
    logic            busy3, h_valid3, ej0_valid3, ks_valid3, ks_last3, done3;

    int checks   = 0;
    int failures = 0;
    int hs1      = 0;
    int ksv_cnt1 = 0;
    int done_cnt1 = 0;
    int done_cnt3 = 0;

    logic [128:0] sb[$];
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data  = '0;
    logic         prev_last  = 1'b0;

    logic [127:0] prev_pt3   = '0;
    logic         prev_busy3 = 1'b0;
    int           age3       = 0;
    int           age3_next;

    always #5 clk = ~clk;

    aes_gctr_sched #(.AES_LAT(1), .NB_W(NB_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .key(key), .j0(j0), .num_blocks(num_blocks),
        .aes_pt(aes_pt1), .aes_key(aes_key1), .aes_ct(aes_ct1),
        .busy(busy1), .h_out(h_out1), .h_valid(h_valid1),
        .ej0_out(ej0_out1), .ej0_valid(ej0_valid1),
        .ks_data(ks_data1), .ks_valid(ks_valid1), .ks_ready(ks_ready1),
        .ks_last(ks_last1), .done(done1)
    );

    aes_gctr_sched #(.AES_LAT(LAT3), .NB_W(NB_W)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort),
        .key(key), .j0(j0), .num_blocks(num_blocks),
        .aes_pt(aes_pt3), .aes_key(aes_key3), .aes_ct(aes_ct3),
        .busy(busy3), .h_out(h_out3), .h_valid(h_valid3),
        .ej0_out(ej0_out3), .ej0_valid(ej0_valid3),
        .ks_data(ks_data3), .ks_valid(ks_valid3), .ks_ready(ks_ready3),
        .ks_last(ks_last3), .done(done3)
    );

    // Stand-in cipher: real GCM test-case values for the zero key, an invertible mix otherwise.
    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] x;
        if (k == 128'h0 && p == 128'h0) return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        if (k == 128'h0 && p == 128'h1) return 128'h58e2fccefa7e3061367f1d57a4e7455a;
        if (k == 128'h0 && p == 128'h2) return 128'h0388dace60b6a392f328c2b971b2fe78;
        x = p ^ k;
        x = {x[114:0], x[127:115]} + 128'h9e3779b97f4a7c15f39cc0605cedc834;
        return x ^ (x >> 7);
    endfunction

    assign aes_ct1 = aes_model(aes_key1, aes_pt1);

    // The slow instance sees a valid result only once aes_pt has been stable for LAT3 cycles.
    always_comb begin
        age3_next = (prev_busy3 && busy3 && (aes_pt3 == prev_pt3)) ? age3 + 1 : 0;
        aes_ct3   = (age3_next == LAT3 - 1) ? aes_model(aes_key3, aes_pt3)
                                            : ~aes_model(aes_key3, aes_pt3);
    end

    always @(posedge clk) begin
        prev_pt3   <= aes_pt3;
        prev_busy3 <= busy3;
        age3       <= age3_next;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ks(input logic [127:0] k, input logic [127:0] j, input int n);
        logic [31:0] lw;
        for (int i = 1; i <= n; i++) begin
            lw = j[31:0] + 32'(i);
            sb.push_back({(i == n), aes_model(k, {j[127:32], lw})});
        end
    endtask

    task automatic wait_done1(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done1) break;
            tick();
        end
        chk(tag, 128'(done1), 128'(1));
    endtask

    // Keystream monitor: scoreboard pop on handshake, hold-stability under stall.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", 128'(ks_valid1), 128'(1));
                chk("stall_data", ks_data1, prev_data);
                chk("stall_last", 128'(ks_last1), 128'(prev_last));
            end
            if (ks_valid1 && ks_ready1) begin
                hs1++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 128'(sb.size()), 128'(1));
                end else begin
                    logic [128:0] e;
                    e = sb.pop_front();
                    chk("ks_data", ks_data1, e[127:0]);
                    chk("ks_last", 128'(ks_last1), 128'(e[128]));
                    $display("ks handshake %0d data=%h last=%0d", hs1, ks_data1, ks_last1);
                end
            end
            if (ks_valid1) ksv_cnt1++;
            if (done1) done_cnt1++;
            if (done3) done_cnt3++;
            prev_stall = ks_valid1 && !ks_ready1 && !abort;
            prev_data  = ks_data1;
            prev_last  = ks_last1;
        end
    end

    initial begin
        logic [127:0] k, jj;
        int hsb, kvb, dcb;

        rst_n = 1'b0; abort = 1'b0; key = '0; j0 = '0; num_blocks = '0;
        start1 = 1'b0; start3 = 1'b0; ks_ready1 = 1'b1; ks_ready3 = 1'b1;
        tick(); tick();
        chk("rst_busy", 128'(busy1), 128'(0));
        chk("rst_hv", 128'(h_valid1), 128'(0));
        chk("rst_ev", 128'(ej0_valid1), 128'(0));
        chk("rst_ksv", 128'(ks_valid1), 128'(0));
        chk("rst_done", 128'(done1), 128'(0));
        chk("rst_hout", h_out1, 128'h0);
        chk("rst_ksd", ks_data1, 128'h0);
        chk("rst_key", aes_key1, 128'h0);
        rst_n = 1'b1;
        tick();

        // Zero key, J0=1, one block: known GCM values
        key = '0; j0 = 128'h1; num_blocks = 16'd1;
        push_ks(key, j0, 1);
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("t1_busy", 128'(busy1), 128'(1));
        chk("t1_hv0", 128'(h_valid1), 128'(0));
        chk("t1_pt_h", aes_pt1, 128'h0);
        tick();
        chk("t1_hv", 128'(h_valid1), 128'(1));
        chk("t1_h", h_out1, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        chk("t1_pt_j0", aes_pt1, 128'h1);
        tick();
        chk("t1_ev", 128'(ej0_valid1), 128'(1));
        chk("t1_ej0", ej0_out1, 128'h58e2fccefa7e3061367f1d57a4e7455a);
        chk("t1_pt_ks", aes_pt1, 128'h2);
        tick();
        chk("t1_ksv", 128'(ks_valid1), 128'(1));
        chk("t1_ksl", 128'(ks_last1), 128'(1));
        chk("t1_ksd", ks_data1, 128'h0388dace60b6a392f328c2b971b2fe78);
        tick();
        chk("t1_done", 128'(done1), 128'(1));
        chk("t1_ksv_off", 128'(ks_valid1), 128'(0));
        tick();
        chk("t1_done_off", 128'(done1), 128'(0));
        chk("t1_idle", 128'(busy1), 128'(0));
        chk("t1_hv_hold", 128'(h_valid1), 128'(1));

        // Counter wrap of the low word, upper 96 bits fixed
        k = 128'h000102030405060708090a0b0c0d0e0f;
        jj = {96'hcafebabedeadbeef01234567, 32'hffff_fffe};
        key = k; j0 = jj; num_blocks = 16'd3;
        push_ks(k, jj, 3);
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick();
        chk("t2_pt_j0", aes_pt1, jj);
        tick();
        chk("t2_pt_c1", aes_pt1, {jj[127:32], 32'hffff_ffff});
        tick(); tick();
        chk("t2_pt_c2", aes_pt1, {jj[127:32], 32'h0000_0000});
        tick(); tick();
        chk("t2_pt_c3", aes_pt1, {jj[127:32], 32'h0000_0001});
        chk("t2_key", aes_key1, k);
        chk("t2_h", h_out1, aes_model(k, 128'h0));
        chk("t2_ej0", ej0_out1, aes_model(k, jj));
        wait_done1("t2_done", 20);
        tick();
        chk("t2_sb_drain", 128'(sb.size()), 128'(0));

        // Four blocks under random back-pressure; inputs scrambled after start
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        jj = {96'h112233445566778899aabbcc, 32'h0000_0010};
        key = k; j0 = jj; num_blocks = 16'd4;
        hsb = hs1;
        push_ks(k, jj, 4);
        start1 = 1'b1; tick(); start1 = 1'b0;
        key = ~k; j0 = ~jj; num_blocks = 16'd9;
        for (int i = 0; i < 300; i++) begin
            if (done1) break;
            ks_ready1 = 1'($urandom_range(0, 1));
            tick();
        end
        chk("t3_done", 128'(done1), 128'(1));
        chk("t3_hs", 128'(hs1 - hsb), 128'(4));
        chk("t3_sb_drain", 128'(sb.size()), 128'(0));
        ks_ready1 = 1'b1;
        tick();

        // Zero blocks, second start while busy must be ignored
        k = 128'hfeedfacecafef00d0badc0de12345678;
        jj = {96'h0f0e0d0c0b0a090807060504, 32'h0000_0100};
        key = k; j0 = jj; num_blocks = 16'd0;
        hsb = hs1; kvb = ksv_cnt1;
        start1 = 1'b1; tick();
        key = ~k; j0 = ~jj; num_blocks = 16'd5;
        tick(); start1 = 1'b0;
        chk("t4_hv", 128'(h_valid1), 128'(1));
        chk("t4_h", h_out1, aes_model(k, 128'h0));
        chk("t4_key", aes_key1, k);
        tick();
        chk("t4_ev", 128'(ej0_valid1), 128'(1));
        chk("t4_ej0", ej0_out1, aes_model(k, jj));
        chk("t4_done", 128'(done1), 128'(1));
        tick();
        chk("t4_done_off", 128'(done1), 128'(0));
        chk("t4_idle", 128'(busy1), 128'(0));
        tick(); tick();
        chk("t4_no_ksv", 128'(ksv_cnt1 - kvb), 128'(0));
        chk("t4_no_hs", 128'(hs1 - hsb), 128'(0));

        // Abort while a keystream block is held
        k = 128'h00112233445566778899aabbccddeeff;
        jj = {96'h123456789abcdef012345678, 32'h0000_0020};
        key = k; j0 = jj; num_blocks = 16'd3;
        push_ks(k, jj, 3);
        ks_ready1 = 1'b0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ks_valid1) break;
            tick();
        end
        chk("t5_ksv", 128'(ks_valid1), 128'(1));
        tick();
        dcb = done_cnt1;
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_idle", 128'(busy1), 128'(0));
        chk("t5_ksv_off", 128'(ks_valid1), 128'(0));
        chk("t5_ksl_off", 128'(ks_last1), 128'(0));
        chk("t5_hv_off", 128'(h_valid1), 128'(0));
        chk("t5_ev_off", 128'(ej0_valid1), 128'(0));
        sb.delete();
        ks_ready1 = 1'b1;
        tick(); tick(); tick();
        chk("t5_no_done", 128'(done_cnt1 - dcb), 128'(0));
        k = 128'h7f7e7d7c7b7a79787776757473727170;
        jj = {96'haaaabbbbccccddddeeeeffff, 32'h7fff_ffff};
        key = k; j0 = jj; num_blocks = 16'd2;
        hsb = hs1;
        push_ks(k, jj, 2);
        start1 = 1'b1; tick(); start1 = 1'b0;
        wait_done1("t5_done", 20);
        chk("t5_hs", 128'(hs1 - hsb), 128'(2));
        chk("t5_sb_drain", 128'(sb.size()), 128'(0));
        chk("t5_h", h_out1, aes_model(k, 128'h0));
        tick();

        // AES_LAT=3 instance: latency, sampling point, async reset mid-keystream
        k = 128'h0123456789abcdeffedcba9876543210;
        jj = {96'h5555666677778888aaaa9999, 32'h0000_0040};
        key = k; j0 = jj; num_blocks = 16'd2;
        start3 = 1'b1; tick(); start3 = 1'b0;
        tick(); tick();
        chk("t6_hv_early", 128'(h_valid3), 128'(0));
        tick();
        chk("t6_hv", 128'(h_valid3), 128'(1));
        chk("t6_h", h_out3, aes_model(k, 128'h0));
        for (int i = 0; i < 20; i++) begin
            if (ej0_valid3) break;
            tick();
        end
        chk("t6_ej0", ej0_out3, aes_model(k, jj));
        for (int i = 0; i < 20; i++) begin
            if (ks_valid3) break;
            tick();
        end
        chk("t6_ksv", 128'(ks_valid3), 128'(1));
        chk("t6_ksd", ks_data3, aes_model(k, {jj[127:32], 32'h0000_0041}));
        chk("t6_ksl", 128'(ks_last3), 128'(0));
        dcb = done_cnt3;
        tick();
        chk("t6_ksv_off", 128'(ks_valid3), 128'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 128'(busy3), 128'(0));
        chk("t6_rst_hv", 128'(h_valid3), 128'(0));
        chk("t6_rst_h", h_out3, 128'h0);
        chk("t6_rst_ej0", ej0_out3, 128'h0);
        chk("t6_rst_ksd", ks_data3, 128'h0);
        chk("t6_rst_key", aes_key3, 128'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_no_done", 128'(done_cnt3 - dcb), 128'(0));
        chk("t6_idle", 128'(busy3), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
